// File: rtl/vsd_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
// Optional averaging is enabled by defining VSD_SAR_AVG4_EN.
package vsd_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    TRIAL,
    DONE
  } state_t;

  localparam int ADC_WIDTH = 10;
  // Four conversions are summed, so the average is the sum shifted right by 2.
  localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/vsd_sar_reg.sv
// Successive-approximation register: bit pointer plus trial code, with
// init (MSB-only trial), per-bit decide from the comparator, and a last-bit flag.
module vsd_sar_reg
  import vsd_adc_pkg::*;
#(
  parameter int WIDTH = ADC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             decide,
  input  logic             clear,
  input  logic             cmp,
  output logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [WIDTH-1:0] next_code;

  // NOTE: every variable gets its default before the conditional updates, so no latch is inferred.
  always_comb begin
    result      = code;
    result[ptr] = cmp;
    next_code   = result;
    if (ptr != '0) next_code[ptr - PTR_W'(1)] = 1'b1;
  end

  assign last = (ptr == '0);

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
      ptr  <= '0;
    end else if (clear) begin
      code <= '0;
      ptr  <= '0;
    end else if (init) begin
      code <= WIDTH'(1) << (WIDTH - 1);
      ptr  <= PTR_W'(WIDTH - 1);
    end else if (decide) begin
      code <= next_code;
      if (ptr != '0) ptr <= ptr - PTR_W'(1);
    end
  end

endmodule

// File: rtl/vsd_sar_adc_ctrl.sv
// SAR ADC controller: track/hold, bit-by-bit trial, valid/ready result with overrun flag.
// Define VSD_SAR_AVG4_EN to average four back-to-back conversions per start.
module vsd_sar_adc_ctrl
  import vsd_adc_pkg::*;
#(
  parameter int WIDTH         = ADC_WIDTH,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             CMP,
  output logic             SAMPLE,
  output logic [WIDTH-1:0] DAC_D,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               accept, retrack, finish;
  logic               reg_init, reg_decide, reg_clear;
  logic [WIDTH-1:0]   sar_result, final_code;
  logic               sar_last;

`ifdef VSD_SAR_AVG4_EN
  logic [1:0]         conv_cnt;
  logic [WIDTH+1:0]   acc, sum;
`endif

  vsd_sar_reg #(.WIDTH(WIDTH)) u_sar_reg (
    .clk    (CLK),
    .rst_n  (reset),
    .init   (reg_init),
    .decide (reg_decide),
    .clear  (reg_clear),
    .cmp    (CMP),
    .code   (DAC_D),
    .result (sar_result),
    .last   (sar_last)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    retrack    = 1'b0;
    finish     = 1'b0;
    reg_init   = 1'b0;
    reg_decide = 1'b0;
    reg_clear  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = TRACK;
      end
      TRACK: if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
        reg_init   = 1'b1;
        state_next = TRIAL;
      end
      TRIAL: if (cnt == CNT_W'(SETTLE_CYCLES)) begin
        reg_decide = 1'b1;
        if (sar_last) begin
`ifdef VSD_SAR_AVG4_EN
          if (conv_cnt != 2'd3) begin
            retrack    = 1'b1;
            reg_clear  = 1'b1;
            state_next = TRACK;
          end else begin
            finish     = 1'b1;
            state_next = DONE;
          end
`else
          finish     = 1'b1;
          state_next = DONE;
`endif
        end
      end
      DONE: begin
        reg_clear  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef VSD_SAR_AVG4_EN
  assign sum        = acc + {2'b00, sar_result};
  assign final_code = WIDTH'(sum >> AVG_SHIFT);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      conv_cnt <= '0;
    end else if (accept) begin
      acc      <= '0;
      conv_cnt <= '0;
    end else if (retrack) begin
      acc      <= sum;
      conv_cnt <= conv_cnt + 2'd1;
    end
  end
`else
  assign final_code = sar_result;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      SAMPLE     <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A reload with a simultaneous consume is not an overwrite.
      overrun <= finish && dout_valid && !dout_ready;

      if (accept || reg_init || reg_decide) cnt <= '0;
      else if (state == TRACK || state == TRIAL) cnt <= cnt + CNT_W'(1);

      if (accept || retrack) SAMPLE <= 1'b1;
      else if (reg_init)     SAMPLE <= 1'b0;

      if (accept)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;

      if (finish) begin
        dout       <= final_code;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vsd_sar_adc_ctrl.sv
// Scoreboard bench for vsd_sar_adc_ctrl (default build) with an ideal comparator model.
module tb_vsd_sar_adc_ctrl;

  localparam int W = 10;

  typedef struct {
    logic [W-1:0] code;
    logic         ovr;
  } exp_t;

  logic         CLK, reset, start, CMP, SAMPLE, busy, dout_valid, dout_ready, overrun;
  logic [W-1:0] DAC_D, dout, vin;

  exp_t exp_q[$];
  int   total = 0, bad = 0, cyc = 0, n_results = 0, n_pushed = 0;

  vsd_sar_adc_ctrl dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .CMP        (CMP),
    .SAMPLE     (SAMPLE),
    .DAC_D      (DAC_D),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  assign CMP = (vin >= DAC_D);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_conv(input logic [W-1:0] v, input logic ovr_exp, input bit push);
    exp_t e;
    vin = v;
    if (push) begin
      e.code = v;
      e.ovr  = ovr_exp;
      exp_q.push_back(e);
      n_pushed++;
    end
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (busy && n < budget);
    check("wait_done_timeout", busy, 0);
  endtask

  // Monitor: a busy fall outside reset marks a DONE; compare against the queue head.
  initial begin
    logic prev_busy;
    int   rise_cyc;
    exp_t e;
    prev_busy = 1'b0;
    rise_cyc  = 0;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) rise_cyc = cyc;
        if (!busy && prev_busy) begin
          n_results++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got dout 0x%0h expected no result", dout);
          end else begin
            e = exp_q.pop_front();
            check("dout", dout, e.code);
            check("dout_valid_at_done", dout_valid, 1);
            check("overrun_at_done", overrun, e.ovr);
            check("latency", cyc - rise_cyc, 22);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] dac_seq [5];
    dac_seq[0] = 10'h200; dac_seq[1] = 10'h300; dac_seq[2] = 10'h280;
    dac_seq[3] = 10'h2C0; dac_seq[4] = 10'h2A0;

    reset = 1'b0; start = 1'b0; vin = '0; dout_ready = 1'b1;
    #12;
    check("rst_sample", SAMPLE, 0);
    check("rst_dac", DAC_D, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_overrun", overrun, 0);
    #10 reset = 1'b1;

    // Mid-scale pattern: trial sequence, SAMPLE width, DAC release after DONE.
    start_conv(10'h2AA, 1'b0, 1'b1);
    check("t1_busy_e0", busy, 1);
    check("t1_sample_e0", SAMPLE, 1);
    check("t1_dac_e0", DAC_D, 0);
    @(posedge CLK); #1;
    check("t1_sample_e1", SAMPLE, 1);
    @(posedge CLK); #1;
    check("t1_sample_e2", SAMPLE, 0);
    check("t1_dac_e2", DAC_D, dac_seq[0]);
    for (int k = 1; k < 5; k++) begin
      repeat (2) @(posedge CLK);
      #1 check($sformatf("t1_dac_bit%0d", k), DAC_D, dac_seq[k]);
    end
    wait_done(100);
    check("t1_dac_final", DAC_D, 10'h2AA);
    @(posedge CLK); #1;
    check("t1_dac_cleared", DAC_D, 0);
    check("t1_valid_consumed", dout_valid, 0);
    check("t1_dout_held", dout, 10'h2AA);

    // Rail codes with a ready consumer.
    start_conv(10'h000, 1'b0, 1'b1);
    wait_done(100);
    start_conv(10'h3FF, 1'b0, 1'b1);
    wait_done(100);

    // Start re-pulsed mid-conversion is ignored.
    start_conv(10'h0F0, 1'b0, 1'b1);
    repeat (4) @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    check("t3_busy_mid", busy, 1);
    wait_done(100);
    repeat (30) @(negedge CLK);
    check("t3_no_restart", busy, 0);
    check("t3_result_count", n_results, n_pushed);

    // Overwrite of an unconsumed sample.
    dout_ready = 1'b0;
    start_conv(10'h100, 1'b0, 1'b1);
    wait_done(100);
    start_conv(10'h155, 1'b1, 1'b1);
    wait_done(100);
    @(posedge CLK); #1;
    check("t4_overrun_pulse_end", overrun, 0);
    check("t4_valid_kept", dout_valid, 1);
    check("t4_dout", dout, 10'h155);
    dout_ready = 1'b1;
    @(posedge CLK); #1;
    check("t4_valid_cleared", dout_valid, 0);

    // Consume and reload on the same edge.
    dout_ready = 1'b0;
    start_conv(10'h0AA, 1'b0, 1'b1);
    wait_done(100);
    start_conv(10'h3A5, 1'b0, 1'b1);
    repeat (21) @(posedge CLK);
    #1 dout_ready = 1'b1;
    @(posedge CLK); #1 dout_ready = 1'b0;
    @(posedge CLK); #1;
    check("t5_valid_reloaded", dout_valid, 1);
    check("t5_dout", dout, 10'h3A5);
    check("t5_no_overrun", overrun, 0);
    dout_ready = 1'b1;
    @(posedge CLK); #1;

    // Reset mid-conversion aborts without a result.
    start_conv(10'h2F0, 1'b0, 1'b0);
    repeat (10) @(posedge CLK);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_sample", SAMPLE, 0);
    check("t6_rst_dac", DAC_D, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_dout", dout, 0);
    check("t6_rst_valid", dout_valid, 0);
    check("t6_rst_overrun", overrun, 0);
    #20 reset = 1'b1;
    start_conv(10'h3C3, 1'b0, 1'b1);
    wait_done(100);

    repeat (5) @(negedge CLK);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_result_count", n_results, n_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vsd_sar_adc_ctrl.md
Name: vsd_sar_adc_ctrl

Overview:
Digital successive-approximation controller for an on-chip SAR ADC, the analog-in counterpart of the core-to-DAC output path.
- Drives a WIDTH-bit trial code into a capacitive/resistive trial DAC and reads back a single-bit analog comparator.
- Resolves one bit per step and hands the finished sample to the core over a valid/ready handshake.
- Clocked from the PLL clock domain (CLK).

Parameters:
WIDTH, 10, resolution in bits; matches the 10-bit DAC path.
SAMPLE_CYCLES, 2, cycles SAMPLE is held high for track/hold (minimum 1).
SETTLE_CYCLES, 1, extra cycles after each trial-code change before CMP is sampled (0 allowed).

Ports:
CLK  input  1  system clock from PLL.
reset  input  1  asynchronous, active-low reset: asserted when 0, released synchronously to CLK by the top-level reset synchroniser.
start  input  1  conversion request, level-sampled in IDLE.
CMP  input  1  comparator output: 1 when Vin >= Vtrial; pre-synchronised externally.
SAMPLE  output  1  track/hold control, 1 = track.
DAC_D  output  WIDTH  trial code to the SAR DAC.
busy  output  1  conversion in progress.
dout  output  WIDTH  converted sample.
dout_valid  output  1  dout holds an unconsumed sample.
dout_ready  input  1  consumer accepts the sample.
overrun  output  1  one-cycle pulse: an unconsumed sample was overwritten.

Behaviour:
- Reset (reset=0, asynchronous) forces these values immediately:
  - state IDLE; SAMPLE=0, DAC_D=0, busy=0, dout=0, dout_valid=0, overrun=0;
  - bit pointer and counters cleared.
- Reset mid-conversion aborts with no partial result. SAMPLE drops asynchronously.
- FSM states: IDLE, TRACK, TRIAL, DONE.
  - IDLE: start=1 at an edge -> TRACK. busy=1 and SAMPLE=1 from that edge.
  - TRACK: held SAMPLE_CYCLES cycles. On exit:
    - SAMPLE=0;
    - DAC_D = MSB-only (1<<(WIDTH-1)), i.e. 0x200 at the default width;
    - bit pointer = WIDTH-1.
  - TRIAL: each bit occupies 1+SETTLE_CYCLES cycles. On the last edge of the window, CMP is sampled:
    - CMP=1 keeps the bit; CMP=0 clears it;
    - the next lower bit is set in DAC_D in the same update.
    - After the LSB decision -> DONE.
  - DONE (single edge, not a dwell state):
    - the final code is latched into dout; dout_valid=1, busy=0;
    - DAC_D returns to 0 on the following cycle;
    - -> IDLE.
- Latency: dout_valid rises SAMPLE_CYCLES + WIDTH*(1+SETTLE_CYCLES) cycles after the start-accepting edge. This is 22 cycles at the defaults.
- start while busy is ignored, with no queuing. start held high gives back-to-back conversions, with IDLE lasting exactly 1 cycle.
- Handshake:
  - dout_valid falls on the edge where dout_valid && dout_ready.
  - dout is stable while dout_valid=1 and is changed only by a new DONE.
- Overwrite case: DONE while dout_valid=1 and dout_ready=0 replaces dout, keeps dout_valid=1, and pulses overrun for 1 cycle.
- Simultaneous case: DONE with dout_valid && dout_ready on the same edge counts as consume plus reload. dout_valid stays 1 and there is no overrun.
- Edge codes: CMP constant 1 -> dout = all ones; CMP constant 0 -> dout = 0. There is no saturation logic beyond this.

Optional Feature:
Macro VSD_SAR_AVG4_EN.
- Defined:
  - each accepted start runs 4 conversions back-to-back (TRACK+TRIAL each);
  - results are summed in a WIDTH+2-bit accumulator;
  - dout = sum>>2 (truncate);
  - only the final DONE asserts dout_valid; busy stays 1 throughout;
  - latency = 4x the base latency.
- Undefined: a single conversion per start, as specified above. No accumulator logic is present.

Decomposition:
- Package vsd_adc_pkg holds:
  - the FSM state enum (IDLE/TRACK/TRIAL/DONE);
  - default width constant ADC_WIDTH=10;
  - the averaging shift constant AVG_SHIFT=2.
- One sub-module is natural: vsd_sar_reg. It contains the bit pointer plus the trial/result register, with init, decide(CMP), and last-bit flag.
- The FSM, counters, and handshake stay in the top.

Test Plan:
- Ideal comparator model CMP = (vin >= DAC_D), vin=0x2AA, start pulse -> DAC_D sequence 0x200,0x300,0x280,0x2C0,0x2A0,... ; dout=0x2AA and dout_valid exactly 22 cycles after the start edge; SAMPLE high for 2 cycles.
- vin=0 and vin=0x3FF -> dout=0x000 and 0x3FF respectively; overrun never asserted with dout_ready=1.
- start re-pulsed at cycle 5 of a conversion -> ignored; exactly one result; busy continuous 1 until DONE.
- dout_ready=0, two conversions (vin 0x100 then 0x155) -> dout=0x155, overrun pulse 1 cycle at the second DONE, dout_valid stays 1; dout_ready=1 next cycle clears it.
- reset driven low at cycle 10 of a conversion -> all outputs 0 immediately; after release, start with vin=0x3C3 -> dout=0x3C3.
- With VSD_SAR_AVG4_EN, vin alternating 0x100/0x101/0x102/0x103 per conversion -> dout=0x101, valid after 88 cycles.
